// File: rtl/board_controller.sv
// board_controller: holds the 3x3 tic-tac-toe board, alternates X/O moves and resolves win/draw.
// Optional per-turn forfeit timer is compiled in when BOARD_TIMEOUT_EN is defined.
module board_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_cell,
    output logic       move_ready,
    input  logic       Xwins,
    input  logic       Owins,
    output logic [1:0] topLeft,
    output logic [1:0] topCenter,
    output logic [1:0] topRight,
    output logic [1:0] middleLeft,
    output logic [1:0] middleCenter,
    output logic [1:0] middleRight,
    output logic [1:0] bottonLeft,
    output logic [1:0] bottonCenter,
    output logic [1:0] bottonRight,
    output logic       turn_x,
    output logic       move_error,
    output logic [3:0] move_count,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       draw,
    output logic       timeout
);

    // state | meaning
    // PLAY  | waiting for the current player's move
    // CHECK | move just placed; win checker outputs sampled this cycle
    // DONE  | game ended by win or draw; board frozen until new_game/reset
    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [1:0]  cells [9];
    logic        turnX;
    logic [3:0]  moveCount;
    logic        errorPulse;
    logic        timeoutPulse;
    logic [1:0]  winnerReg;
    logic        drawReg;

    logic        targetFree;
    logic        accept;
    logic        reject;
    logic        expire;
    logic        moverWins;
    logic [1:0]  moverCode;

    assign moverCode = turnX ? 2'b10 : 2'b01;
    assign moverWins = turnX ? Xwins : Owins;

    always_comb begin
        targetFree = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (move_cell == 4'(i)) targetFree = (cells[i] == 2'b00);
        end
    end

    assign accept = (state == PLAY) && move_valid && (move_cell <= 4'd8) && targetFree;
    assign reject = (state == PLAY) && move_valid && !((move_cell <= 4'd8) && targetFree);

`ifdef BOARD_TIMEOUT_EN
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    logic [TimerW-1:0] turnTimer;

    // Counts idle PLAY cycles; held at zero outside PLAY so each turn starts fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            turnTimer <= '0;
        end else if (new_game || (state != PLAY) || accept || expire) begin
            turnTimer <= '0;
        end else begin
            turnTimer <= turnTimer + 1'b1;
        end
    end

    assign expire = (state == PLAY) && !accept && (turnTimer == TimerLast);
`else
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = ^TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PLAY;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            PLAY: begin
                if (accept) nextState = CHECK;
            end
            CHECK: begin
                if (moverWins || (moveCount == 4'd9)) nextState = DONE;
                else                                 nextState = PLAY;
            end
            DONE: begin
                nextState = DONE;
            end
            default: begin
                nextState = PLAY;
            end
        endcase
        if (new_game) nextState = PLAY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) cells[i] <= 2'b00;
            turnX        <= 1'b1;
            moveCount    <= 4'd0;
            errorPulse   <= 1'b0;
            timeoutPulse <= 1'b0;
            winnerReg    <= 2'b00;
            drawReg      <= 1'b0;
        end else if (new_game) begin
            for (int i = 0; i < 9; i++) cells[i] <= 2'b00;
            turnX        <= 1'b1;
            moveCount    <= 4'd0;
            errorPulse   <= 1'b0;
            timeoutPulse <= 1'b0;
            winnerReg    <= 2'b00;
            drawReg      <= 1'b0;
        end else begin
            errorPulse   <= reject;
            timeoutPulse <= expire;
            if (accept) begin
                for (int i = 0; i < 9; i++) begin
                    if (move_cell == 4'(i)) cells[i] <= moverCode;
                end
                moveCount <= moveCount + 4'd1;
            end
            if (expire) turnX <= ~turnX;
            // Only the mover's flag matters; the other player cannot have just completed a line.
            if (state == CHECK) begin
                if (moverWins) begin
                    winnerReg <= moverCode;
                end else if (moveCount == 4'd9) begin
                    drawReg <= 1'b1;
                end else begin
                    turnX <= ~turnX;
                end
            end
        end
    end

    assign topLeft      = cells[0];
    assign topCenter    = cells[1];
    assign topRight     = cells[2];
    assign middleLeft   = cells[3];
    assign middleCenter = cells[4];
    assign middleRight  = cells[5];
    assign bottonLeft   = cells[6];
    assign bottonCenter = cells[7];
    assign bottonRight  = cells[8];

    assign move_ready = (state == PLAY);
    assign game_over  = (state == DONE);
    assign turn_x     = turnX;
    assign move_count = moveCount;
    assign move_error = errorPulse;
    assign timeout    = timeoutPulse;
    assign winner     = winnerReg;
    assign draw       = drawReg;

endmodule

// File: tb/tb_board_controller.sv
// Bench for board_controller: game-level model compared every cycle, plus pinned literal expectations.
`timescale 1ns/1ps
module tb_board_controller;

    localparam int T = 8;

    localparam int F_TURN = 9;
    localparam int F_READY = 10;
    localparam int F_ERR = 11;
    localparam int F_COUNT = 12;
    localparam int F_OVER = 13;
    localparam int F_WINNER = 14;
    localparam int F_DRAW = 15;
    localparam int F_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       new_game = 1'b0;
    logic       move_valid = 1'b0;
    logic [3:0] move_cell = 4'd0;
    logic       Xwins;
    logic       Owins;
    logic       bogusO = 1'b0;
    logic       move_ready;
    logic [1:0] topLeft, topCenter, topRight;
    logic [1:0] middleLeft, middleCenter, middleRight;
    logic [1:0] bottonLeft, bottonCenter, bottonRight;
    logic       turn_x;
    logic       move_error;
    logic [3:0] move_count;
    logic       game_over;
    logic [1:0] winner;
    logic       draw;
    logic       timeout;

    board_controller #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .new_game(new_game),
        .move_valid(move_valid), .move_cell(move_cell), .move_ready(move_ready),
        .Xwins(Xwins), .Owins(Owins),
        .topLeft(topLeft), .topCenter(topCenter), .topRight(topRight),
        .middleLeft(middleLeft), .middleCenter(middleCenter), .middleRight(middleRight),
        .bottonLeft(bottonLeft), .bottonCenter(bottonCenter), .bottonRight(bottonRight),
        .turn_x(turn_x), .move_error(move_error), .move_count(move_count),
        .game_over(game_over), .winner(winner), .draw(draw), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic hasLine(input logic [1:0] b [9], input logic [1:0] c);
        return (b[0] == c && b[1] == c && b[2] == c) || (b[3] == c && b[4] == c && b[5] == c) ||
               (b[6] == c && b[7] == c && b[8] == c) || (b[0] == c && b[3] == c && b[6] == c) ||
               (b[1] == c && b[4] == c && b[7] == c) || (b[2] == c && b[5] == c && b[8] == c) ||
               (b[0] == c && b[4] == c && b[8] == c) || (b[2] == c && b[4] == c && b[6] == c);
    endfunction

    // Stand-in win checker driven from the DUT's cell outputs; bogusO injects a spurious O flag.
    logic [1:0] dutCells [9];
    always_comb begin
        dutCells[0] = topLeft;    dutCells[1] = topCenter;    dutCells[2] = topRight;
        dutCells[3] = middleLeft; dutCells[4] = middleCenter; dutCells[5] = middleRight;
        dutCells[6] = bottonLeft; dutCells[7] = bottonCenter; dutCells[8] = bottonRight;
        Xwins = hasLine(dutCells, 2'b10);
        Owins = hasLine(dutCells, 2'b01) | bogusO;
    end

    // Game model
    logic [1:0] mBoard [9] = '{default: 2'b00};
    bit         mTurnX = 1'b1;
    int         mCount = 0;
    bit         mPending = 1'b0;
    bit         mOver = 1'b0;
    bit         mErr = 1'b0;
    bit         mTo = 1'b0;
    logic [1:0] mWinner = 2'b00;
    bit         mDraw = 1'b0;
    int         mIdle = 0;

    task automatic modelClear();
        for (int i = 0; i < 9; i++) mBoard[i] = 2'b00;
        mTurnX = 1'b1; mCount = 0; mPending = 1'b0; mOver = 1'b0;
        mErr = 1'b0; mTo = 1'b0; mWinner = 2'b00; mDraw = 1'b0; mIdle = 0;
    endtask

    task automatic modelStep();
        logic [1:0] code;
        mErr = 1'b0;
        mTo = 1'b0;
        code = mTurnX ? 2'b10 : 2'b01;
        if (new_game) begin
            modelClear();
        end else if (mPending) begin
            mPending = 1'b0;
            mIdle = 0;
            if (hasLine(mBoard, code)) begin
                mOver = 1'b1; mWinner = code;
            end else if (mCount == 9) begin
                mOver = 1'b1; mDraw = 1'b1;
            end else begin
                mTurnX = !mTurnX;
            end
        end else if (!mOver) begin
            if (move_valid && move_cell <= 4'd8 && mBoard[move_cell] == 2'b00) begin
                mBoard[move_cell] = code;
                mCount++;
                mPending = 1'b1;
                mIdle = 0;
            end else begin
                if (move_valid) mErr = 1'b1;
`ifdef BOARD_TIMEOUT_EN
                if (mIdle == T - 1) begin
                    mTurnX = !mTurnX; mTo = 1'b1; mIdle = 0;
                end else begin
                    mIdle++;
                end
`endif
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) modelClear();
        else       modelStep();
    end

    // Literal pins: written by the stimulus process, consumed by the compare process.
    typedef struct {
        string name;
        int    field;
        int    val;
    } pinT;
    pinT pins [128];
    int  litWr = 0;
    int  litRd = 0;
    int  checks = 0;
    int  failures = 0;

    task automatic pin(input string n, input int f, input int v);
        pins[litWr] = '{n, f, v};
        litWr++;
    endtask

    function automatic int fieldVal(input int f);
        case (f)
            0: return int'(topLeft);
            1: return int'(topCenter);
            2: return int'(topRight);
            3: return int'(middleLeft);
            4: return int'(middleCenter);
            5: return int'(middleRight);
            6: return int'(bottonLeft);
            7: return int'(bottonCenter);
            8: return int'(bottonRight);
            F_TURN: return int'(turn_x);
            F_READY: return int'(move_ready);
            F_ERR: return int'(move_error);
            F_COUNT: return int'(move_count);
            F_OVER: return int'(game_over);
            F_WINNER: return int'(winner);
            F_DRAW: return int'(draw);
            F_TIMEOUT: return int'(timeout);
            default: return -1;
        endcase
    endfunction

    logic [29:0] actV;
    logic [29:0] expV;

    always @(negedge clk) begin
        actV = {topLeft, topCenter, topRight, middleLeft, middleCenter, middleRight,
                bottonLeft, bottonCenter, bottonRight, turn_x, move_ready, move_error,
                move_count, game_over, winner, draw, timeout};
        expV = {mBoard[0], mBoard[1], mBoard[2], mBoard[3], mBoard[4], mBoard[5],
                mBoard[6], mBoard[7], mBoard[8], mTurnX, !mPending && !mOver, mErr,
                4'(mCount), mOver, mWinner, mDraw, mTo};
        checks++;
        if (actV !== expV) begin
            failures++;
            $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, actV, expV);
        end
        while (litRd < litWr) begin
            checks++;
            if (fieldVal(pins[litRd].field) != pins[litRd].val) begin
                failures++;
                $display("FAIL %s t=%0t actual=%0d required=%0d", pins[litRd].name, $time,
                         fieldVal(pins[litRd].field), pins[litRd].val);
            end
            litRd++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic play(input logic [3:0] c);
        move_valid = 1'b1;
        move_cell = c;
        cyc(1);
        move_valid = 1'b0;
        cyc(1);
    endtask

    task automatic newGame();
        new_game = 1'b1;
        cyc(1);
        new_game = 1'b0;
    endtask

    initial begin
        cyc(3);
        reset = 1'b0;
        pin("reset_turn", F_TURN, 1);
        pin("reset_ready", F_READY, 1);
        pin("reset_count", F_COUNT, 0);
        pin("reset_over", F_OVER, 0);

        // X takes the top row; a bogus O flag during X's check must be ignored.
        play(0); play(4);
        bogusO = 1'b1; play(1); bogusO = 1'b0;
        play(8); play(2);
        pin("xwin_over", F_OVER, 1);
        pin("xwin_winner", F_WINNER, 2);
        pin("xwin_count", F_COUNT, 5);
        pin("xwin_ready", F_READY, 0);
        pin("xwin_topRight", 2, 2);

        // Occupied and out-of-range targets
        newGame();
        pin("ng_count", F_COUNT, 0);
        play(4);
        move_valid = 1'b1; move_cell = 4'd4; cyc(1); move_valid = 1'b0;
        pin("occ_err", F_ERR, 1);
        pin("occ_center", 4, 2);
        pin("occ_turn", F_TURN, 0);
        pin("occ_count", F_COUNT, 1);
        cyc(1);
        pin("occ_err_end", F_ERR, 0);
        move_valid = 1'b1; move_cell = 4'd12; cyc(1); move_valid = 1'b0;
        pin("range_err", F_ERR, 1);
        pin("range_count", F_COUNT, 1);
        pin("range_turn", F_TURN, 0);
        cyc(1);
        pin("range_err_end", F_ERR, 0);

        // Draw: X 0,2,3,7,8 and O 1,4,5,6
        newGame();
        play(0); play(1); play(2); play(4); play(3);
        play(5); play(7); play(6); play(8);
        pin("draw_flag", F_DRAW, 1);
        pin("draw_winner", F_WINNER, 0);
        pin("draw_count", F_COUNT, 9);
        pin("draw_over", F_OVER, 1);

        // Requests in DONE are ignored; new_game wins over a simultaneous move
        move_valid = 1'b1; move_cell = 4'd0;
        cyc(2);
        pin("done_err", F_ERR, 0);
        pin("done_cell5", 5, 1);
        pin("done_count", F_COUNT, 9);
        new_game = 1'b1;
        cyc(1);
        new_game = 1'b0; move_valid = 1'b0;
        pin("ngmv_topLeft", 0, 0);
        pin("ngmv_center", 4, 0);
        pin("ngmv_turn", F_TURN, 1);
        pin("ngmv_count", F_COUNT, 0);
        pin("ngmv_ready", F_READY, 1);
        pin("ngmv_draw", F_DRAW, 0);

        // Reset during CHECK clears everything before the next edge
        move_valid = 1'b1; move_cell = 4'd0; cyc(1); move_valid = 1'b0;
        #2 reset = 1'b1;
        pin("rst_topLeft", 0, 0);
        pin("rst_count", F_COUNT, 0);
        pin("rst_ready", F_READY, 1);
        pin("rst_turn", F_TURN, 1);
        cyc(1);
        reset = 1'b0;

`ifdef BOARD_TIMEOUT_EN
        cyc(7);
        pin("to_before", F_TIMEOUT, 0);
        pin("to_turn_before", F_TURN, 1);
        cyc(1);
        pin("to_pulse", F_TIMEOUT, 1);
        pin("to_turn_after", F_TURN, 0);
        cyc(7);
        move_valid = 1'b1; move_cell = 4'd0; cyc(1); move_valid = 1'b0;
        pin("expiry_accept_to", F_TIMEOUT, 0);
        pin("expiry_accept_cell", 0, 1);
        pin("expiry_accept_ready", F_READY, 0);
        cyc(1);
        pin("expiry_check_to", F_TIMEOUT, 0);
        pin("expiry_check_turn", F_TURN, 1);
`else
        cyc(12);
        pin("noto_pulse", F_TIMEOUT, 0);
        pin("noto_turn", F_TURN, 1);
`endif

        cyc(2);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
